// File: rtl/machine_sw_debounce.sv
// Switch conditioning ahead of the switch adder: 2-flop synchroniser, per-bit
// debounce FSM, registered change pulse and a sticky startup-valid flag.
module machine_sw_debounce #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw,
   output logic             sw_changed,
   output logic             sw_valid
);

   typedef enum logic {
      STABLE = 1'b0,
      COUNT  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W:0]   START_ONE  = (CNT_W + 1)'(1);
   localparam logic [CNT_W:0]   START_DONE = (CNT_W + 1)'(DEBOUNCE_CYCLES + 2);

   state_t           state_q [WIDTH];
   state_t           state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] sw_q;
   logic [WIDTH-1:0] sw_d;
   logic             changed_q;
   logic             changed_d;
   logic [CNT_W:0]   start_q;
   logic [CNT_W:0]   start_d;
   logic             valid_q;
   logic             valid_d;

   // Any disagreement between the synchronised pin and the accepted value must
   // persist for the full window; a single agreeing sample restarts it.
   always_comb begin
      sw_d = sw_q;
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            STABLE: begin
               cnt_d[i] = '0;
               if (sync2_q[i] != sw_q[i]) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     sw_d[i] = sync2_q[i];
                  end else begin
                     cnt_d[i]   = CNT_ONE;
                     state_d[i] = COUNT;
                  end
               end
            end
            COUNT: begin
               if (sync2_q[i] == sw_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = STABLE;
               end else if (cnt_q[i] == CNT_LAST) begin
                  sw_d[i]    = sync2_q[i];
                  cnt_d[i]   = '0;
                  state_d[i] = STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = STABLE;
            end
         endcase
      end
      changed_d = (sw_d != sw_q);
      start_d   = (start_q == START_DONE) ? start_q : start_q + START_ONE;
      valid_d   = valid_q | (start_d == START_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         sw_q      <= '0;
         changed_q <= 1'b0;
         start_q   <= '0;
         valid_q   <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q   <= sw_raw;
         sync2_q   <= sync1_q;
         sw_q      <= sw_d;
         changed_q <= changed_d;
         start_q   <= start_d;
         valid_q   <= valid_d;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign sw         = sw_q;
   assign sw_changed = changed_q;
   assign sw_valid   = valid_q;

endmodule

// File: tb/tb_machine_sw_debounce.sv
// Scoreboard bench for machine_sw_debounce with a 4-cycle debounce window:
// stimulus queues expected (value, edge) events, a negedge monitor retires them.
module tb_machine_sw_debounce;

   localparam int N = 4;

   typedef struct packed {
      logic [1:0] swVal;
      int         edgeN;
   } swEvent_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] sw_raw;
   logic [1:0] sw;
   logic       sw_changed;
   logic       sw_valid;

   int         total;
   int         bad;
   int         cyc;
   logic       prevValid;
   swEvent_t   expQ[$];
   int         validQ[$];

   machine_sw_debounce #(
      .WIDTH(2),
      .DEBOUNCE_CYCLES(N),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sw_raw(sw_raw),
      .sw(sw),
      .sw_changed(sw_changed),
      .sw_valid(sw_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge count since the most recent reset release; edge 1 is the first one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Retire expected events whenever the DUT reports a change or valid rise.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sw_changed === 1'b1) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_pulse: got sw=%0d at edge %0d, expected no pulse", sw, cyc);
            end else begin
               swEvent_t e;
               e = expQ.pop_front();
               checkOutput("sw_value", int'(sw), int'(e.swVal));
               checkOutput("sw_edge", cyc, e.edgeN);
            end
         end
         if (sw_valid === 1'b1 && prevValid !== 1'b1) begin
            if (validQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_valid: got rise at edge %0d, expected none", cyc);
            end else begin
               checkOutput("valid_edge", cyc, validQ.pop_front());
            end
         end
      end
      prevValid = sw_valid;
   end

   // Drive sw_raw at a negedge; it is sampled on the next edge k = cyc+1 and
   // a held level reaches sw at edge k+1+N.
   task automatic applyStimulus(input logic [1:0] v, input bit expectChange);
      swEvent_t e;
      @(negedge clk);
      sw_raw = v;
      if (expectChange) begin
         e.swVal = v;
         e.edgeN = cyc + 2 + N;
         expQ.push_back(e);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      prevValid = 1'b0;
      sw_raw    = 2'b00;
      rst_n     = 1'b0;

      // Test 1: quiet startup
      waitCycles(3);
      checkOutput("reset_sw", int'(sw), 0);
      checkOutput("reset_changed", int'(sw_changed), 0);
      checkOutput("reset_valid", int'(sw_valid), 0);
      validQ.push_back(N + 2);
      rst_n = 1'b1;
      waitCycles(8);
      checkOutput("valid_held", int'(sw_valid), 1);

      // Test 2: single bit rise
      applyStimulus(2'b01, 1'b1);
      waitCycles(10);

      // Test 3: bounce on bit0 restarts the window
      applyStimulus(2'b00, 1'b1);
      waitCycles(10);
      begin
         swEvent_t e;
         @(negedge clk);
         sw_raw  = 2'b01;
         e.swVal = 2'b01;
         e.edgeN = cyc + 9;
         expQ.push_back(e);
         waitCycles(2);
         sw_raw = 2'b00;
         waitCycles(1);
         sw_raw = 2'b01;
      end
      waitCycles(12);

      // Test 4: both bits settle on the same edge
      applyStimulus(2'b00, 1'b1);
      waitCycles(10);
      applyStimulus(2'b11, 1'b1);
      waitCycles(10);
      applyStimulus(2'b00, 1'b1);
      waitCycles(10);

      // Test 5: reset mid-count discards progress
      @(negedge clk);
      sw_raw = 2'b01;
      waitCycles(4);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_sw", int'(sw), 0);
      checkOutput("midreset_valid", int'(sw_valid), 0);
      checkOutput("midreset_changed", int'(sw_changed), 0);
      waitCycles(1);
      begin
         swEvent_t e;
         e.swVal = 2'b01;
         e.edgeN = N + 2;
         expQ.push_back(e);
         validQ.push_back(N + 2);
      end
      rst_n = 1'b1;
      waitCycles(10);

      // Test 6: switch held high through reset
      sw_raw = 2'b10;
      rst_n  = 1'b0;
      #1;
      checkOutput("reset6_sw", int'(sw), 0);
      waitCycles(2);
      begin
         swEvent_t e;
         e.swVal = 2'b10;
         e.edgeN = N + 2;
         expQ.push_back(e);
         validQ.push_back(N + 2);
      end
      rst_n = 1'b1;
      waitCycles(10);
      checkOutput("final_sw", int'(sw), 2);

      checkOutput("pending_changes", expQ.size(), 0);
      checkOutput("pending_valids", validQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
